memory_2rw_wb_pipe: RTL and testbench

Parametrised successor to the testbench dual-port Wishbone memory. Two pipelined Wishbone B4 slave ports share one byte-addressable array, with configurable data width, depth and ack latency. Out-of-range accesses return an error response, and aborted cycles are handled. Used in CPU testbenches as combined instruction/data memory (port0 = LSU, port1 = fetch) to exercise latency- and error-tolerant bus behaviour.

---
 rtl/memory_2rw_wb_pipe.sv | 117 +++++++++++
 tb/tb_memory_2rw_wb_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_2rw_wb_pipe.sv
// memory_2rw_wb_pipe: two pipelined Wishbone B4 slave ports over one byte array, fixed ack latency, err on out-of-range
// Optional MEMORY_STALL_INJECT_EN adds per-port LFSR-driven stall injection.
module memory_2rw_wb_pipe #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 11,
  parameter int          LATENCY      = 1,
  parameter int          STALL_WEIGHT = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      port0_wb_clk_i,
  input  logic                      port0_wb_rst_i,
  input  logic                      port0_wb_cyc_i,
  input  logic                      port0_wb_stb_i,
  input  logic                      port0_wb_we_i,
  input  logic [31:0]               port0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     port0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   port0_wb_sel_i,
  output logic                      port0_wb_stall_o,
  output logic                      port0_wb_ack_o,
  output logic                      port0_wb_err_o,
  output logic [DATA_WIDTH-1:0]     port0_wb_dat_o,
  input  logic                      port1_wb_cyc_i,
  input  logic                      port1_wb_stb_i,
  input  logic                      port1_wb_we_i,
  input  logic [31:0]               port1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     port1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   port1_wb_sel_i,
  output logic                      port1_wb_stall_o,
  output logic                      port1_wb_ack_o,
  output logic                      port1_wb_err_o,
  output logic [DATA_WIDTH-1:0]     port1_wb_dat_o
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int BAW = ADDR_WIDTH + $clog2(NB);
  logic [7:0] mem [2**BAW];
  logic [1:0] cyc, stb, we, stall, acc, bad, ack, err;
  logic [1:0][31:0] adr;
  logic [1:0][DATA_WIDTH-1:0] wdat, rd, rdat;
  logic [1:0][NB-1:0] sel, wen;
  logic [1:0][NB-1:0][BAW-1:0] idx;
  genvar g, i;
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || LATENCY < 1 || LATENCY > 8 ||
      STALL_WEIGHT < 0 || STALL_WEIGHT > 16 || LFSR_SEED == 16'h0) begin : g_cfg_err
    $error("memory_2rw_wb_pipe: unsupported parameter set");
  end
  assign cyc  = {port1_wb_cyc_i, port0_wb_cyc_i};
  assign stb  = {port1_wb_stb_i, port0_wb_stb_i};
  assign we   = {port1_wb_we_i,  port0_wb_we_i};
  assign adr  = {port1_wb_adr_i, port0_wb_adr_i};
  assign wdat = {port1_wb_dat_i, port0_wb_dat_i};
  assign sel  = {port1_wb_sel_i, port0_wb_sel_i};
  assign {port1_wb_stall_o, port0_wb_stall_o} = stall;
  assign {port1_wb_ack_o,   port0_wb_ack_o}   = ack;
  assign {port1_wb_err_o,   port0_wb_err_o}   = err;
  assign port0_wb_dat_o = rdat[0];
  assign port1_wb_dat_o = rdat[1];
  for (g = 0; g < 2; g++) begin : gp
    logic [BAW:0] last;
    logic [LATENCY-1:0] v, e;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] d;
    // Carry into bit BAW means the access runs past the top of the array.
    assign last   = {1'b0, adr[g][BAW-1:0]} + (BAW+1)'(NB - 1);
    assign bad[g] = (|adr[g][31:BAW]) | last[BAW];
    assign acc[g] = cyc[g] & stb[g] & ~stall[g] & ~port0_wb_rst_i;
    for (i = 0; i < NB; i++) begin : gl
      assign idx[g][i]      = adr[g][BAW-1:0] + BAW'(i);
      assign wen[g][i]      = acc[g] & we[g] & ~bad[g] & sel[g][i];
      assign rd[g][8*i +: 8] = mem[idx[g][i]];
    end
    always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i)
      if (port0_wb_rst_i) begin
        v <= '0;
        e <= '0;
        d <= '0;
      end else if (!cyc[g]) begin
        v <= '0;
        e <= '0;
        d <= '0;
      end else begin
        v[0] <= acc[g];
        e[0] <= acc[g] & bad[g];
        d[0] <= (acc[g] & ~we[g] & ~bad[g]) ? rd[g] : '0;
        for (int k = 1; k < LATENCY; k++) begin
          v[k] <= v[k-1];
          e[k] <= e[k-1];
          d[k] <= d[k-1];
        end
      end
    assign ack[g]  = v[LATENCY-1] & ~e[LATENCY-1];
    assign err[g]  = v[LATENCY-1] & e[LATENCY-1];
    assign rdat[g] = d[LATENCY-1];
`ifdef MEMORY_STALL_INJECT_EN
    function automatic logic [15:0] rev16(input logic [15:0] x);
      for (int b = 0; b < 16; b++) rev16[b] = x[15-b];
    endfunction
    localparam logic [15:0] SEED = (g == 0) ? LFSR_SEED : rev16(LFSR_SEED);
    logic [15:0] lfsr;
    logic        stall_r;
    always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i)
      if (port0_wb_rst_i) begin
        lfsr    <= SEED;
        stall_r <= 1'b0;
      end else begin
        lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        stall_r <= cyc[g] & ({1'b0, lfsr[3:0]} < 5'(STALL_WEIGHT));
      end
    assign stall[g] = stall_r;
`else
    assign stall[g] = 1'b0;
`endif
  end
  // Port1 lanes are written first so port0 overrides on a same-byte collision.
  always_ff @(posedge port0_wb_clk_i)
    for (int p = 1; p >= 0; p--)
      for (int k = 0; k < NB; k++)
        if (wen[p][k]) mem[idx[p][k]] <= wdat[p][8*k +: 8];
endmodule

// File: tb/tb_memory_2rw_wb_pipe.sv
// tb_memory_2rw_wb_pipe: scoreboard bench for memory_2rw_wb_pipe (32-bit, 8 KiB, latency 3)
module tb_memory_2rw_wb_pipe;
  localparam int LAT = 3;
  localparam int NB = 4;
  localparam int DEPTH = 8192;
  typedef struct {
    int          due;
    bit          err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc[2], stb[2], we[2], stall[2], ack[2], err[2];
  logic [31:0] adr[2], dat[2], rdat[2];
  logic [3:0] sel[2];
  logic [7:0] mdl [DEPTH];
  exp_t q[2][$];
  bit acc[2];
  int cyc_n = 0, compared = 0, mismatched = 0;

  memory_2rw_wb_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .LATENCY(LAT)) dut (
    .port0_wb_clk_i(clk), .port0_wb_rst_i(rst),
    .port0_wb_cyc_i(cyc[0]), .port0_wb_stb_i(stb[0]), .port0_wb_we_i(we[0]),
    .port0_wb_adr_i(adr[0]), .port0_wb_dat_i(dat[0]), .port0_wb_sel_i(sel[0]),
    .port0_wb_stall_o(stall[0]), .port0_wb_ack_o(ack[0]), .port0_wb_err_o(err[0]),
    .port0_wb_dat_o(rdat[0]),
    .port1_wb_cyc_i(cyc[1]), .port1_wb_stb_i(stb[1]), .port1_wb_we_i(we[1]),
    .port1_wb_adr_i(adr[1]), .port1_wb_dat_i(dat[1]), .port1_wb_sel_i(sel[1]),
    .port1_wb_stall_o(stall[1]), .port1_wb_ack_o(ack[1]), .port1_wb_err_o(err[1]),
    .port1_wb_dat_o(rdat[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input int p, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s port%0d @cycle %0d: got %h expected %h", nm, p, cyc_n, act, req);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return ({32'h0, a} + 64'(NB - 1)) >= 64'(DEPTH);
  endfunction

  // Monitor: every response must match the oldest expectation, in the cycle it is due.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst)
      for (int p = 0; p < 2; p++) begin
`ifndef MEMORY_STALL_INJECT_EN
        check("stall tied low", p, 32'(stall[p]), 32'h0);
`endif
        while (q[p].size() != 0 && q[p][0].due < cyc_n) begin
          check("missed response", p, 32'(0), 32'h1);
          void'(q[p].pop_front());
        end
        if (ack[p] || err[p]) begin
          if (q[p].size() == 0 || q[p][0].due != cyc_n)
            check("unexpected response ack/err", p, {30'h0, ack[p], err[p]}, 32'h0);
          else begin
            e = q[p].pop_front();
            check("ack", p, 32'(ack[p]), 32'(!e.err));
            check("err", p, 32'(err[p]), 32'(e.err));
            if (e.chk) check("read data", p, rdat[p], e.dat);
          end
        end else if (q[p].size() != 0 && q[p][0].due == cyc_n) begin
          e = q[p].pop_front();
          check("absent response ack/err", p, {30'h0, ack[p], err[p]}, e.err ? 32'h1 : 32'h2);
        end
      end
  end

  // One bus cycle: predict responses from the reference array, then advance to the next negedge.
  task automatic step();
    exp_t e;
    for (int p = 0; p < 2; p++) acc[p] = cyc[p] && stb[p] && !stall[p];
    for (int p = 0; p < 2; p++)
      if (acc[p]) begin
        e.err = oor(adr[p]);
        e.chk = !we[p];
        e.dat = '0;
        e.due = cyc_n + LAT;
        if (!e.err && !we[p])
          for (int b = 0; b < NB; b++) e.dat[8*b +: 8] = mdl[adr[p] + 32'(b)];
        q[p].push_back(e);
      end
    for (int p = 1; p >= 0; p--)
      if (acc[p] && we[p] && !oor(adr[p]))
        for (int b = 0; b < NB; b++)
          if (sel[p][b]) mdl[adr[p] + 32'(b)] = dat[p][8*b +: 8];
    for (int p = 0; p < 2; p++)
      if (!cyc[p])
        while (q[p].size() != 0 && q[p][$].due >= cyc_n + 1) void'(q[p].pop_back());
    @(negedge clk);
    #1;
  endtask

  task automatic req(input int p, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; adr[p] = a; dat[p] = d; sel[p] = s;
  endtask

  task automatic run();
    int n = 0;
    while ((stb[0] || stb[1]) && n < 1000) begin
      step();
      for (int p = 0; p < 2; p++) if (acc[p]) stb[p] = 1'b0;
      n++;
    end
    for (int p = 0; p < 2; p++) if (stb[p]) begin check("accept timeout stb", p, 32'(stb[p]), 32'h0); stb[p] = 1'b0; end
  endtask

  task automatic hold(input int p);
    int n = 0;
    do begin step(); n++; end while (!acc[p] && n < 1000);
    if (!acc[p]) check("accept timeout", p, 32'(acc[p]), 32'h1);
  endtask

  task automatic rnd_req(input int p);
    int r = int'($urandom_range(0, 15));
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'h1FF0 + 32'($urandom_range(0, 15));
      1: a = $urandom;
      default: a = 32'($urandom_range(0, 255));
    endcase
    if (r == 0) begin cyc[p] = 1'b0; stb[p] = 1'b0; end
    else if (r < 4) begin cyc[p] = 1'b1; stb[p] = 1'b0; end
    else req(p, 1'($urandom), a, $urandom, 4'($urandom));
  endtask

  initial begin
    int nx[2];
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d expected < 20000", cyc_n);
    $fatal(1);
  end

  initial begin
    int nx[2];
    for (int p = 0; p < 2; p++) begin
      cyc[p] = 0; stb[p] = 0; we[p] = 0; adr[p] = 0; dat[p] = 0; sel[p] = 0;
    end
    for (int k = 0; k < DEPTH; k++) mdl[k] = 8'h00;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check("reset ack", p, 32'(ack[p]), 32'h0);
      check("reset err", p, 32'(err[p]), 32'h0);
      check("reset stall", p, 32'(stall[p]), 32'h0);
      check("reset dat", p, rdat[p], 32'h0);
    end
    rst = 1'b0;
    #1;
    // Zero the whole array through both ports so the model starts from known contents.
    nx[0] = 0; nx[1] = 4;
    req(0, 1, 32'(nx[0]), 0, 4'hF);
    req(1, 1, 32'(nx[1]), 0, 4'hF);
    for (int n = 0; (stb[0] || stb[1]) && n < 20000; n++) begin
      step();
      for (int p = 0; p < 2; p++)
        if (acc[p]) begin
          nx[p] += 8;
          if (nx[p] < DEPTH) adr[p] = 32'(nx[p]); else stb[p] = 1'b0;
        end
    end
    stb[0] = 0; stb[1] = 0;
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF); run();
    req(0, 0, 32'h10, 0, 4'hF); run();
    req(0, 1, 32'h21, 32'h11223344, 4'b0110); run();
    req(0, 0, 32'h20, 0, 4'h0); run();
    for (int k = 0; k < 4; k++) begin req(1, 0, 32'h10 + 32'(k * 8), 0, 4'hF); hold(1); end
    stb[1] = 0;
    req(0, 1, 32'h40, 32'h000000AA, 4'b0001);
    req(1, 1, 32'h40, 32'h00000055, 4'b0001); run();
    req(0, 0, 32'h40, 0, 4'hF); run();
    req(0, 0, 32'h10, 0, 4'hF);
    req(1, 1, 32'h10, 32'h12345678, 4'hF); run();
    req(1, 0, 32'h10, 0, 4'hF); run();
    req(0, 0, 32'h1FFE, 0, 4'hF); run();
    req(0, 1, 32'h1FFE, 32'hFFFFFFFF, 4'hF); run();
    req(0, 1, 32'h1FFD, 32'hFFFFFFFF, 4'hF); run();
    req(1, 1, 32'h8000_0010, 32'hCAFEF00D, 4'hF); run();
    req(1, 0, 32'h8000_0010, 0, 4'hF); run();
    req(0, 1, 32'h1FFC, 32'hA5A5A5A5, 4'hF); run();
    req(0, 0, 32'h1FFC, 0, 4'hF); run();
    req(1, 0, 32'h10, 0, 4'hF); run();
    req(0, 0, 32'h10, 0, 4'hF); hold(0);
    stb[0] = 0; cyc[0] = 0;
    step(); step();
    cyc[0] = 1;
    repeat (LAT + 2) step();
    for (int p = 0; p < 2; p++) rnd_req(p);
    repeat (3000) begin
      step();
      for (int p = 0; p < 2; p++) if (acc[p] || !stb[p]) rnd_req(p);
    end
    cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
    repeat (LAT + 2) step();
    for (int k = 0; k < 1000; k++) begin req(1, 0, 32'($urandom_range(0, DEPTH - 1)), 0, 4'hF); hold(1); end
    stb[1] = 0;
    repeat (LAT + 3) step();
    for (int p = 0; p < 2; p++) check("outstanding at end", p, 32'(q[p].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
